// File: rtl/grid_cell_highlighter.sv
// Overlays COLOR on one selected cell of a ROWS x COLS grid; selection is double-buffered and applied at frame_start.
// Latency: slc_on/ocolor are registered, one cycle after hcount/vcount. Optional blink with GRID_HL_BLINK_EN.
// Backpressure: none; strobes are always accepted, and out-of-range indices are dropped.
module grid_cell_highlighter #(
  parameter int          COLS         = 2,
  parameter int          ROWS         = 2,
  parameter int          X0           = 141,
  parameter int          Y0           = 38,
  parameter int          CELL_W       = 308,
  parameter int          CELL_H       = 235,
  parameter int          GAP          = 6,
  parameter logic [23:0] COLOR        = 24'h82C3CA,
  parameter int          BLINK_FRAMES = 30,
  localparam int         SW           = $clog2(COLS*ROWS+1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          frame_start,
  input  logic          win,
  input  logic          sel_valid,
  input  logic [SW-1:0] sel_idx,
  input  logic [9:0]    hcount,
  input  logic [9:0]    vcount,
  output logic [23:0]   ocolor,
  output logic          slc_on,
  output logic [SW-1:0] cur_sel
);

  localparam int          NCELL   = COLS*ROWS;
  localparam logic [10:0] PITCH_X = 11'(CELL_W + GAP);
  localparam logic [10:0] PITCH_Y = 11'(CELL_H + GAP);

  typedef struct packed {
    logic [10:0] x_lo;
    logic [10:0] x_hi;
    logic [10:0] y_lo;
    logic [10:0] y_hi;
  } bounds_t;

  if ((X0 + COLS*(CELL_W+GAP) - GAP > 1024) || (Y0 + ROWS*(CELL_H+GAP) - GAP > 1024)) begin : g_geom_chk
    $error("grid_cell_highlighter: grid does not fit in a 1024x1024 display");
  end

  logic [SW-1:0] pending;
  logic [SW-1:0] sel_k;
  logic [SW-1:0] sel_col;
  logic [SW-1:0] sel_row;
  bounds_t       bnd;
  bounds_t       bnd_next;
  logic          sel_ok;
  logic          hit;
  logic          blink_on;
  logic          slc_next;

  assign sel_ok = (sel_idx <= SW'(NCELL));

  // Bounds for pending; a garbage result for pending==0 is masked by cur_sel!=0 in the hit test.
  always_comb begin
    sel_k         = pending - SW'(1);
    sel_col       = sel_k % SW'(COLS);
    sel_row       = sel_k / SW'(COLS);
    bnd_next.x_lo = 11'(X0) + 11'(sel_col) * PITCH_X;
    bnd_next.x_hi = bnd_next.x_lo + 11'(CELL_W - 1);
    bnd_next.y_lo = 11'(Y0) + 11'(sel_row) * PITCH_Y;
    bnd_next.y_hi = bnd_next.y_lo + 11'(CELL_H - 1);
  end

  always_comb begin
    hit = (cur_sel != '0)
       && ({1'b0, hcount} >= bnd.x_lo) && ({1'b0, hcount} <= bnd.x_hi)
       && ({1'b0, vcount} >= bnd.y_lo) && ({1'b0, vcount} <= bnd.y_hi);
    slc_next = hit && !win && blink_on;
  end

`ifdef GRID_HL_BLINK_EN
  localparam int BCW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  logic [BCW-1:0] blink_cnt;
  logic           blink_phase;

  // A changed selection restarts the blink so the new cell shows immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (frame_start) begin
      if (pending != cur_sel) begin
        blink_cnt   <= '0;
        blink_phase <= 1'b1;
      end else if (blink_cnt == BCW'(BLINK_FRAMES - 1)) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt   <= blink_cnt + BCW'(1);
      end
    end
  end

  assign blink_on = blink_phase;
`else
  assign blink_on = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      cur_sel <= '0;
      bnd     <= '0;
      slc_on  <= 1'b0;
      ocolor  <= '0;
    end else begin
      if (frame_start) begin
        cur_sel <= pending;
        bnd     <= bnd_next;
      end
      if (sel_valid && sel_ok) begin
        pending <= sel_idx;
      end
      slc_on <= slc_next;
      ocolor <= slc_next ? COLOR : 24'h0;
    end
  end

endmodule

// File: tb/tb_grid_cell_highlighter.sv
// Directed and randomized checks of grid_cell_highlighter against an arithmetic grid model.
module tb_grid_cell_highlighter;
  localparam int          COLS = 2, ROWS = 2, X0 = 141, Y0 = 38;
  localparam int          CELL_W = 308, CELL_H = 235, GAP = 6, BF = 2;
  localparam int          NCELL = COLS*ROWS, SW = 3;
  localparam logic [23:0] COLOR = 24'h82C3CA;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          frame_start = 1'b0;
  logic          win = 1'b0;
  logic          sel_valid = 1'b0;
  logic [SW-1:0] sel_idx = '0;
  logic [9:0]    hcount = '0;
  logic [9:0]    vcount = '0;
  logic [23:0]   ocolor;
  logic          slc_on;
  logic [SW-1:0] cur_sel;

  int total = 0;
  int bad   = 0;
  int m_pend = 0, m_cur = 0, m_since = 0;

  grid_cell_highlighter #(.BLINK_FRAMES(BF)) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .win(win),
    .sel_valid(sel_valid), .sel_idx(sel_idx), .hcount(hcount), .vcount(vcount),
    .ocolor(ocolor), .slc_on(slc_on), .cur_sel(cur_sel)
  );

  always #5 clk = ~clk;

  // Locate the pixel in the grid by division rather than by cell bounds.
  function automatic bit model_hit(input int sel, input int h, input int v);
    int dx, dy, c, r;
    if (sel == 0 || sel > NCELL || h < X0 || v < Y0) return 1'b0;
    dx = h - X0;
    dy = v - Y0;
    c  = dx / (CELL_W + GAP);
    r  = dy / (CELL_H + GAP);
    if (c >= COLS || r >= ROWS) return 1'b0;
    if ((dx % (CELL_W + GAP)) >= CELL_W || (dy % (CELL_H + GAP)) >= CELL_H) return 1'b0;
    return (r*COLS + c + 1) == sel;
  endfunction

  function automatic bit model_blink();
`ifdef GRID_HL_BLINK_EN
    return ((m_since / BF) % 2) == 0;
`else
    return 1'b1;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle(input bit fs, input bit sv, input int idx);
    frame_start = fs;
    sel_valid   = sv;
    sel_idx     = SW'(idx);
    @(posedge clk);
    if (fs) begin
      if (m_pend != m_cur) m_since = 0;
      else m_since++;
      m_cur = m_pend;
    end
    if (sv && idx <= NCELL) m_pend = idx;
    #1;
    frame_start = 1'b0;
    sel_valid   = 1'b0;
  endtask

  task automatic set_pix(input int h, input int v);
    hcount = 10'(h);
    vcount = 10'(v);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_pix(200, 100);
    for (int i = 0; i < 5; i++) begin
      step();
      total++; if (slc_on !== 1'b0) begin bad++; $display("FAIL reset_slc: got %0b want 0", slc_on); end
      total++; if (ocolor !== 24'h0) begin bad++; $display("FAIL reset_ocolor: got %h want 0", ocolor); end
      total++; if (cur_sel !== '0) begin bad++; $display("FAIL reset_cur_sel: got %0d want 0", cur_sel); end
    end
    rst_n = 1'b1;
    m_pend = 0; m_cur = 0; m_since = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (slc_on !== 1'b0 || ocolor !== 24'h0 || cur_sel !== '0) begin
        bad++; $display("FAIL post_reset: got slc=%0b col=%h sel=%0d want all 0", slc_on, ocolor, cur_sel);
      end
    end
  endtask

  task automatic test_sel_timing();
    cycle(0, 1, 1);
    set_pix(200, 100);
    step();
    total++; if (slc_on !== 1'b0) begin bad++; $display("FAIL pre_frame_slc: got %0b want 0", slc_on); end
    cycle(1, 0, 0);
    total++; if (cur_sel !== SW'(1)) begin bad++; $display("FAIL frame_cur_sel: got %0d want 1", cur_sel); end
    step();
    total++; if (slc_on !== 1'b1) begin bad++; $display("FAIL sel1_slc: got %0b want 1", slc_on); end
    total++; if (ocolor !== COLOR) begin bad++; $display("FAIL sel1_ocolor: got %h want %h", ocolor, COLOR); end
  endtask

  task automatic test_boundaries();
    int bh[5] = '{455, 454, 762, 763, 460};
    int bv[5] = '{279, 279, 513, 513, 278};
    bit be[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    cycle(0, 1, 4);
    cycle(1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      set_pix(bh[i], bv[i]);
      step();
      total++; if (slc_on !== be[i]) begin
        bad++; $display("FAIL bound_slc (%0d,%0d): got %0b want %0b", bh[i], bv[i], slc_on, be[i]);
      end
      total++; if (ocolor !== (be[i] ? COLOR : 24'h0)) begin
        bad++; $display("FAIL bound_ocolor (%0d,%0d): got %h want %h", bh[i], bv[i], ocolor, be[i] ? COLOR : 24'h0);
      end
    end
  endtask

  task automatic test_invalid_clear();
    cycle(0, 1, 5);
    cycle(1, 0, 0);
    total++; if (cur_sel !== SW'(4)) begin bad++; $display("FAIL invalid_ignored: got %0d want 4", cur_sel); end
    cycle(0, 1, 0);
    cycle(1, 0, 0);
    total++; if (cur_sel !== '0) begin bad++; $display("FAIL clear_cur_sel: got %0d want 0", cur_sel); end
    for (int i = 0; i < 8; i++) begin
      set_pix($urandom_range(130, 780), $urandom_range(30, 525));
      step();
      total++; if (slc_on !== 1'b0) begin
        bad++; $display("FAIL clear_slc (%0d,%0d): got %0b want 0", hcount, vcount, slc_on);
      end
    end
  endtask

  task automatic test_win();
    cycle(0, 1, 2);
    cycle(1, 0, 0);
    set_pix(600, 100);
    step();
    total++; if (slc_on !== 1'b1) begin bad++; $display("FAIL win_pre: got %0b want 1", slc_on); end
    win = 1'b1;
    step();
    total++; if (slc_on !== 1'b0) begin bad++; $display("FAIL win_on: got %0b want 0", slc_on); end
    total++; if (cur_sel !== SW'(2)) begin bad++; $display("FAIL win_keeps_sel: got %0d want 2", cur_sel); end
    win = 1'b0;
    step();
    total++; if (slc_on !== 1'b1) begin bad++; $display("FAIL win_off: got %0b want 1", slc_on); end
  endtask

  task automatic test_simultaneous();
    cycle(1, 1, 3);
    total++; if (cur_sel !== SW'(2)) begin bad++; $display("FAIL simul_same_frame: got %0d want 2", cur_sel); end
    cycle(1, 0, 0);
    total++; if (cur_sel !== SW'(3)) begin bad++; $display("FAIL simul_next_frame: got %0d want 3", cur_sel); end
  endtask

  task automatic test_mid_reset();
    cycle(0, 1, 1);
    cycle(1, 0, 0);
    set_pix(200, 100);
    step();
    total++; if (slc_on !== 1'b1) begin bad++; $display("FAIL midrst_pre: got %0b want 1", slc_on); end
    rst_n = 1'b0;
    #1;
    total++; if (slc_on !== 1'b0 || ocolor !== 24'h0 || cur_sel !== '0) begin
      bad++; $display("FAIL midrst_async: got slc=%0b col=%h sel=%0d want all 0", slc_on, ocolor, cur_sel);
    end
    step();
    step();
    rst_n = 1'b1;
    m_pend = 0; m_cur = 0; m_since = 0;
    cycle(1, 0, 0);
    step();
    total++; if (cur_sel !== '0 || slc_on !== 1'b0) begin
      bad++; $display("FAIL midrst_after: got sel=%0d slc=%0b want 0 0", cur_sel, slc_on);
    end
  endtask

`ifdef GRID_HL_BLINK_EN
  task automatic test_blink();
    bit exp_on[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    cycle(0, 1, 1);
    set_pix(200, 100);
    for (int f = 0; f < 8; f++) begin
      cycle(1, 0, 0);
      step();
      total++; if (slc_on !== exp_on[f]) begin
        bad++; $display("FAIL blink_frame%0d: got %0b want %0b", f, slc_on, exp_on[f]);
      end
    end
    cycle(0, 1, 2);
    cycle(1, 0, 0);
    set_pix(600, 100);
    step();
    total++; if (slc_on !== 1'b1) begin bad++; $display("FAIL blink_restart: got %0b want 1", slc_on); end
  endtask
`endif

  task automatic test_random();
    bit fs, sv, exp_on;
    int idx;
    for (int i = 0; i < 400; i++) begin
      set_pix($urandom_range(130, 780), $urandom_range(30, 525));
      win    = ($urandom_range(0, 9) == 0);
      fs     = ($urandom_range(0, 7) == 0);
      sv     = ($urandom_range(0, 3) == 0);
      idx    = $urandom_range(0, 7);
      exp_on = model_hit(m_cur, int'(hcount), int'(vcount)) && !win && model_blink();
      cycle(fs, sv, idx);
      total++; if (slc_on !== exp_on) begin
        bad++; $display("FAIL rand_slc #%0d (%0d,%0d) sel=%0d: got %0b want %0b", i, hcount, vcount, cur_sel, slc_on, exp_on);
      end
      total++; if (ocolor !== (exp_on ? COLOR : 24'h0)) begin
        bad++; $display("FAIL rand_ocolor #%0d: got %h want %h", i, ocolor, exp_on ? COLOR : 24'h0);
      end
      total++; if (cur_sel !== SW'(m_cur)) begin
        bad++; $display("FAIL rand_cur_sel #%0d: got %0d want %0d", i, cur_sel, m_cur);
      end
    end
    win = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sel_timing();
    test_boundaries();
    test_invalid_clear();
    test_win();
    test_simultaneous();
    test_mid_reset();
`ifdef GRID_HL_BLINK_EN
    test_blink();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
